// File: rtl/envelope_pkg.sv
// Envelope shaper shared definitions.
// State encoding and full-scale envelope derivation.
package envelope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

  // All-ones value of a w-bit unsigned envelope (unity gain).
  function automatic logic [31:0] env_max_f(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser with rising-edge detector.
// No edge is reported until the chain holds post-reset samples.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic tick
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic [2:0] fill_q, fill_d;

  // Shift the input through the chain; fill marks valid stages.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    fill_d  = {fill_q[1:0], 1'b1};
  end

  // Chain registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
    end
  end

  assign tick = sync2_q & ~prev_q & fill_q[2];

endmodule

// File: rtl/envelope_shaper.sv
// ADSR envelope generator and sample multiplier.
// Envelope steps once per lrclk tick; output latency is two clocks.
module envelope_shaper
  import envelope_pkg::*;
#(
  parameter int BITSIZE = 24,
  parameter int ENVSIZE = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               lrclk,
  input  logic               gate,
  input  logic [BITSIZE-1:0] in_sample,
  input  logic [ENVSIZE-1:0] attack_step,
  input  logic [ENVSIZE-1:0] decay_step,
  input  logic [ENVSIZE-1:0] release_step,
  input  logic [ENVSIZE-1:0] sustain_level,
  output logic [BITSIZE-1:0] out_sample,
  output logic               out_valid,
  output logic [ENVSIZE-1:0] env_level,
  output logic               busy
);

  localparam int PW = BITSIZE + ENVSIZE + 1;
  localparam logic [ENVSIZE-1:0] ENV_MAX =
    ENVSIZE'(env_max_f(ENVSIZE));
  localparam logic [ENVSIZE:0] ENV_MAX_X = {1'b0, ENV_MAX};

  env_state_e             state_q, state_d;
  logic [ENVSIZE-1:0]     env_q, env_d;
  logic signed [PW-1:0]   prod_q, prod_d;
  logic                   pv_q, pv_d;
  logic [BITSIZE-1:0]     out_q, out_d;
  logic                   ov_q, ov_d;
  logic                   tick;
  logic [ENVSIZE:0]       up, dn_dec, dn_rel;

  edge_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (lrclk),
    .tick     (tick)
  );

  // Widened step arithmetic so saturation never wraps.
  always_comb begin
    up     = {1'b0, env_q} + {1'b0, attack_step};
    dn_dec = {1'b0, env_q} - {1'b0, decay_step};
    dn_rel = {1'b0, env_q} - {1'b0, release_step};
  end

  // Next state and envelope; gate changes win over rate moves.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (tick) begin
      unique case (state_q)
        ST_IDLE: begin
          if (gate) state_d = ST_ATTACK;
        end
        ST_ATTACK: begin
          if (!gate) begin
            state_d = ST_RELEASE;
          end else if (attack_step == '0 || up >= ENV_MAX_X) begin
            env_d   = ENV_MAX;
            state_d = ST_DECAY;
          end else begin
            env_d = up[ENVSIZE-1:0];
          end
        end
        ST_DECAY: begin
          if (!gate) begin
            state_d = ST_RELEASE;
          end else if (decay_step == '0 || env_q <= sustain_level ||
                       dn_dec[ENVSIZE] ||
                       dn_dec[ENVSIZE-1:0] <= sustain_level) begin
            env_d   = sustain_level;
            state_d = ST_SUSTAIN;
          end else begin
            env_d = dn_dec[ENVSIZE-1:0];
          end
        end
        ST_SUSTAIN: begin
          if (!gate) state_d = ST_RELEASE;
          else       env_d   = sustain_level;
        end
        ST_RELEASE: begin
          if (gate) begin
            state_d = ST_ATTACK;
          end else if (release_step == '0 || dn_rel[ENVSIZE] ||
                       dn_rel[ENVSIZE-1:0] == '0) begin
            env_d   = '0;
            state_d = ST_IDLE;
          end else begin
            env_d = dn_rel[ENVSIZE-1:0];
          end
        end
        default: begin
          state_d = ST_IDLE;
          env_d   = '0;
        end
      endcase
    end
  end

  // Multiply with the updated envelope, then scale and truncate.
  always_comb begin
    prod_d = tick
      ? PW'($signed(in_sample)) * PW'($signed({1'b0, env_d}))
      : prod_q;
    pv_d   = tick;
    out_d  = pv_q ? BITSIZE'(prod_q >>> ENVSIZE) : out_q;
    ov_d   = pv_q;
  end

  // State, envelope and pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      prod_q  <= '0;
      pv_q    <= 1'b0;
      out_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      prod_q  <= prod_d;
      pv_q    <= pv_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
    end
  end

  // Output decode.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    env_level  = env_q;
    out_sample = out_q;
    out_valid  = ov_q;
  end

endmodule

// File: tb/tb_envelope_shaper.sv
// Directed bench for envelope_shaper.
// Each task drives one scenario and checks its own results.
module tb_envelope_shaper;
  import envelope_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lrclk = 1'b0;
  logic        gate = 1'b0;
  logic [23:0] in_sample = '0;
  logic [15:0] attack_step = '0;
  logic [15:0] decay_step = '0;
  logic [15:0] release_step = '0;
  logic [15:0] sustain_level = '0;
  logic [23:0] out_sample;
  logic        out_valid;
  logic [15:0] env_level;
  logic        busy;

  int vecs = 0;
  int errs = 0;

  logic        ov1, ov2, ov3;
  logic [23:0] os2;

  envelope_shaper #(.BITSIZE(24), .ENVSIZE(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .lrclk         (lrclk),
    .gate          (gate),
    .in_sample     (in_sample),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .release_step  (release_step),
    .sustain_level (sustain_level),
    .out_sample    (out_sample),
    .out_valid     (out_valid),
    .env_level     (env_level),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // One lrclk period; records out_valid one, two and three
  // clocks after the tick cycle, and out_sample at two.
  task automatic pulse();
    @(negedge clk);
    lrclk = 1'b1;
    repeat (3) @(posedge clk);
    #1 ov1 = out_valid;
    @(posedge clk);
    #1 ov2 = out_valid;
    os2 = out_sample;
    @(posedge clk);
    #1 ov3 = out_valid;
    lrclk = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    logic seen;
    lrclk = 1'b1;
    gate  = 1'b1;
    attack_step = 16'h4000;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (out_sample !== 24'h0) begin
      errs++;
      $display("FAIL rst_out got %h want 0", out_sample);
    end
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_valid got %b want 0", out_valid);
    end
    vecs++;
    if (env_level !== 16'h0) begin
      errs++;
      $display("FAIL rst_env got %h want 0", env_level);
    end
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 seen = seen | out_valid | busy;
    end
    vecs++;
    if (seen !== 1'b0) begin
      errs++;
      $display("FAIL rst_high_lrclk got %b want 0", seen);
    end
    lrclk = 1'b0;
    gate  = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_attack();
    logic [15:0] ee[4] = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
    logic [23:0] eo[4] = '{24'h1FFFFF, 24'h3FFFFF,
                           24'h5FFFFF, 24'h800080};
    gate = 1'b1;
    attack_step = 16'h4000;
    in_sample = 24'h7FFFFF;
    pulse();
    vecs++;
    if (dut.state_q !== ST_ATTACK || env_level !== 16'h0) begin
      errs++;
      $display("FAIL atk_entry got st=%0d env=%h want st=1 env=0",
               dut.state_q, env_level);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) in_sample = 24'h800000;
      pulse();
      vecs++;
      if (env_level !== ee[i]) begin
        errs++;
        $display("FAIL atk_env[%0d] got %h want %h",
                 i, env_level, ee[i]);
      end
      vecs++;
      if (dut.state_q !== ((i == 3) ? ST_DECAY : ST_ATTACK)) begin
        errs++;
        $display("FAIL atk_state[%0d] got %0d", i, dut.state_q);
      end
      vecs++;
      if (os2 !== eo[i]) begin
        errs++;
        $display("FAIL atk_out[%0d] got %h want %h", i, os2, eo[i]);
      end
      vecs++;
      if ({ov1, ov2, ov3} !== 3'b010) begin
        errs++;
        $display("FAIL atk_valid[%0d] got %b want 010",
                 i, {ov1, ov2, ov3});
      end
    end
  endtask

  task automatic test_decay();
    logic [15:0] exp_env;
    decay_step = 16'h1000;
    sustain_level = 16'h8000;
    for (int i = 0; i < 8; i++) begin
      exp_env = (i == 7) ? 16'h8000 : 16'hFFFF - 16'h1000 * 16'(i + 1);
      pulse();
      vecs++;
      if (env_level !== exp_env) begin
        errs++;
        $display("FAIL dec_env[%0d] got %h want %h",
                 i, env_level, exp_env);
      end
      vecs++;
      if (dut.state_q !== ((i == 7) ? ST_SUSTAIN : ST_DECAY)) begin
        errs++;
        $display("FAIL dec_state[%0d] got %0d", i, dut.state_q);
      end
    end
    sustain_level = 16'h7000;
    pulse();
    vecs++;
    if (env_level !== 16'h7000 || dut.state_q !== ST_SUSTAIN) begin
      errs++;
      $display("FAIL sus_track got env=%h st=%0d want 7000/3",
               env_level, dut.state_q);
    end
    sustain_level = 16'h8000;
    pulse();
    vecs++;
    if (env_level !== 16'h8000) begin
      errs++;
      $display("FAIL sus_back got %h want 8000", env_level);
    end
  endtask

  task automatic test_release();
    logic [15:0] ee[4] = '{16'h6000, 16'h4000, 16'h2000, 16'h0000};
    gate = 1'b0;
    release_step = 16'h2000;
    pulse();
    vecs++;
    if (dut.state_q !== ST_RELEASE || env_level !== 16'h8000 ||
        busy !== 1'b1) begin
      errs++;
      $display("FAIL rel_entry got st=%0d env=%h busy=%b",
               dut.state_q, env_level, busy);
    end
    for (int i = 0; i < 4; i++) begin
      pulse();
      vecs++;
      if (env_level !== ee[i]) begin
        errs++;
        $display("FAIL rel_env[%0d] got %h want %h",
                 i, env_level, ee[i]);
      end
    end
    vecs++;
    if (dut.state_q !== ST_IDLE || busy !== 1'b0) begin
      errs++;
      $display("FAIL rel_idle got st=%0d busy=%b want 0/0",
               dut.state_q, busy);
    end
    in_sample = 24'h7FFFFF;
    pulse();
    vecs++;
    if (os2 !== 24'h0 || ov2 !== 1'b1) begin
      errs++;
      $display("FAIL idle_out got %h v=%b want 000000 v=1", os2, ov2);
    end
  endtask

  task automatic test_retrigger();
    gate = 1'b1;
    attack_step = 16'h4000;
    repeat (3) pulse();
    gate = 1'b0;
    release_step = 16'h2000;
    pulse();
    vecs++;
    if (dut.state_q !== ST_RELEASE || env_level !== 16'h8000) begin
      errs++;
      $display("FAIL atk_to_rel got st=%0d env=%h want 4/8000",
               dut.state_q, env_level);
    end
    pulse();
    gate = 1'b1;
    attack_step = 16'h1000;
    pulse();
    vecs++;
    if (dut.state_q !== ST_ATTACK || env_level !== 16'h6000) begin
      errs++;
      $display("FAIL retrig got st=%0d env=%h want 1/6000",
               dut.state_q, env_level);
    end
    pulse();
    vecs++;
    if (env_level !== 16'h7000) begin
      errs++;
      $display("FAIL retrig_step got %h want 7000", env_level);
    end
  endtask

  task automatic test_zero_steps();
    attack_step = 16'h0;
    pulse();
    vecs++;
    if (env_level !== 16'hFFFF || dut.state_q !== ST_DECAY) begin
      errs++;
      $display("FAIL atk0 got env=%h st=%0d want FFFF/2",
               env_level, dut.state_q);
    end
    decay_step = 16'h0;
    sustain_level = 16'h3000;
    pulse();
    vecs++;
    if (env_level !== 16'h3000 || dut.state_q !== ST_SUSTAIN) begin
      errs++;
      $display("FAIL dec0 got env=%h st=%0d want 3000/3",
               env_level, dut.state_q);
    end
    gate = 1'b0;
    release_step = 16'h0;
    pulse();
    pulse();
    vecs++;
    if (env_level !== 16'h0 || dut.state_q !== ST_IDLE) begin
      errs++;
      $display("FAIL rel0 got env=%h st=%0d want 0/0",
               env_level, dut.state_q);
    end
  endtask

  task automatic test_clamp();
    gate = 1'b1;
    attack_step = 16'hF000;
    pulse();
    pulse();
    pulse();
    vecs++;
    if (env_level !== 16'hFFFF || dut.state_q !== ST_DECAY) begin
      errs++;
      $display("FAIL atk_sat got env=%h st=%0d want FFFF/2",
               env_level, dut.state_q);
    end
    decay_step = 16'hF000;
    sustain_level = 16'h2000;
    pulse();
    vecs++;
    if (env_level !== 16'h2000 || dut.state_q !== ST_SUSTAIN) begin
      errs++;
      $display("FAIL dec_clamp got env=%h st=%0d want 2000/3",
               env_level, dut.state_q);
    end
    gate = 1'b0;
    release_step = 16'h3000;
    pulse();
    pulse();
    vecs++;
    if (env_level !== 16'h0 || dut.state_q !== ST_IDLE) begin
      errs++;
      $display("FAIL rel_clamp got env=%h st=%0d want 0/0",
               env_level, dut.state_q);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    gate = 1'b1;
    attack_step = 16'h0;
    decay_step = 16'h0;
    sustain_level = 16'h8000;
    in_sample = 24'h7FFFFF;
    repeat (3) pulse();
    vecs++;
    if (dut.state_q !== ST_SUSTAIN || os2 !== 24'h3FFFFF) begin
      errs++;
      $display("FAIL mid_setup got st=%0d out=%h want 3/3FFFFF",
               dut.state_q, os2);
    end
    @(negedge clk);
    lrclk = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    vecs++;
    if (out_sample !== 24'h0 || out_valid !== 1'b0 ||
        env_level !== 16'h0 || busy !== 1'b0 ||
        dut.state_q !== ST_IDLE) begin
      errs++;
      $display("FAIL mid_reset got out=%h v=%b env=%h busy=%b",
               out_sample, out_valid, env_level, busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 seen = seen | out_valid | busy;
    end
    vecs++;
    if (seen !== 1'b0) begin
      errs++;
      $display("FAIL mid_no_tick got %b want 0", seen);
    end
    lrclk = 1'b0;
    repeat (3) @(posedge clk);
    pulse();
    vecs++;
    if ({ov1, ov2, ov3} !== 3'b010 || os2 !== 24'h0 ||
        dut.state_q !== ST_ATTACK) begin
      errs++;
      $display("FAIL mid_first_tick got v=%b out=%h st=%0d",
               {ov1, ov2, ov3}, os2, dut.state_q);
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_decay();
    test_release();
    test_retrigger();
    test_zero_steps();
    test_clamp();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/envelope_shaper.md
ENVELOPE_SHAPER -- requirements
Module: envelope_shaper

Interface
REQ-001 SHALL have parameter BITSIZE, default 24: audio sample width, two's complement.
REQ-002 SHALL have parameter ENVSIZE, default 16: envelope width, unsigned; ENV_MAX = 2^ENVSIZE-1 represents unity gain.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port lrclk  input  1  I2S word clock, asynchronous to clk; one rising edge per stereo sample.
REQ-006 SHALL have port gate  input  1  note on (1) / off (0), synchronous to clk.
REQ-007 SHALL have port in_sample  input  BITSIZE  signed sample from the tone generator.
REQ-008 SHALL have ports attack_step, decay_step, release_step  input  ENVSIZE  per-sample envelope increments.
REQ-009 SHALL have port sustain_level  input  ENVSIZE  sustain envelope value.
REQ-010 SHALL have port out_sample  output  BITSIZE  shaped signed sample to the I2S transmitter.
REQ-011 SHALL have port out_valid  output  1  one-clk pulse when out_sample updates.
REQ-012 SHALL have port env_level  output  ENVSIZE  current envelope value.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL synchronise lrclk through two flip-flops and generate a one-clk "tick" on each rising edge of the synchronised signal.
REQ-015 SHALL evaluate gate, update envelope and state, and capture in_sample only on tick; all of these SHALL hold between ticks.
REQ-016 SHALL implement states IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-017 On tick with gate=1 in IDLE or RELEASE: SHALL enter ATTACK with env unchanged (retrigger from current level, no reset to 0).
REQ-018 On tick with gate=0 in ATTACK, DECAY or SUSTAIN: SHALL enter RELEASE with env unchanged.
REQ-019 ATTACK: env += attack_step, saturating at ENV_MAX; on reaching ENV_MAX SHALL enter DECAY. attack_step=0 SHALL set env=ENV_MAX immediately.
REQ-020 DECAY: env -= decay_step, clamped at sustain_level; on reaching it SHALL enter SUSTAIN. decay_step=0 or env<=sustain_level SHALL set env=sustain_level and enter SUSTAIN.
REQ-021 SUSTAIN: env SHALL equal sustain_level each tick (tracks live changes).
REQ-022 RELEASE: env -= release_step, clamped at 0; on reaching 0 SHALL enter IDLE. release_step=0 SHALL set env=0 immediately.
REQ-023 Gate transitions SHALL take priority over rate-driven transitions on the same tick.
REQ-024 Saturation/clamp SHALL use ENVSIZE+1-bit intermediate arithmetic; env SHALL never wrap.
REQ-025 Output SHALL be (in_sample x {0,env}) arithmetically shifted right by ENVSIZE, truncated toward minus infinity, using the env value after that tick's update.
REQ-026 Pipeline: multiply registered one clk after tick, out_sample and out_valid registered two clk after tick; fixed latency 2.
REQ-027 In IDLE, out_sample SHALL be 0 from the first output following entry.

Reset
REQ-028 Reset SHALL force state=IDLE, env=0, out_sample=0, out_valid=0, busy=0, synchroniser and pipeline registers=0, immediately and mid-operation.
REQ-029 After reset release, first tick SHALL occur only on a synchronised lrclk rising edge; lrclk high at release SHALL NOT produce a tick.

Structure
REQ-030 State encoding (3 bits) and ENV_MAX derivation SHALL live in shared package envelope_pkg.
REQ-031 The lrclk synchroniser and edge detector SHALL be sub-module edge_sync; the rest stays flat.

Verification (ENVSIZE=16, BITSIZE=24)
REQ-032 attack_step=0x4000, gate=1 from IDLE -> env 0x4000, 0x8000, 0xC000, 0xFFFF on 4 ticks, then state DECAY.
REQ-033 decay_step=0x1000, sustain_level=0x8000 from 0xFFFF -> SUSTAIN at 0x8000 on tick 8; then gate=0, release_step=0x2000 -> env 0 and IDLE, busy=0 after 4 ticks.
REQ-034 env=0x8000, in_sample=0x7FFFFF -> out_sample=0x3FFFFF with out_valid exactly 2 clk after tick; env=0xFFFF, in_sample=0x800000 -> 0x800080.
REQ-035 Retrigger: gate 1 while RELEASE at env 0x6000 -> ATTACK, next tick env=0x6000+attack_step.
REQ-036 Reset asserted in SUSTAIN mid-pipeline -> out_sample=0, out_valid=0, env=0, IDLE without waiting for clk; no out_valid until first tick after release.
